// File: rtl/pep_batch_scheduler.sv
// PBS batch scheduler: allocates HPU slots circularly, groups requests into batches
// and issues them on size, idle timeout, flush or full occupancy; tracks in-order release.
module pep_batch_scheduler #(
  parameter int BATCH_PBS_NB = 9,
  parameter int TOTAL_PBS_NB = 18,
  parameter int GRAM_NB      = 3,
  parameter int TIMEOUT      = 64,
  localparam int PID_W = $clog2(TOTAL_PBS_NB),
  localparam int GID_W = (GRAM_NB > 1) ? $clog2(GRAM_NB) : 1,
  localparam int NB_W  = $clog2(BATCH_PBS_NB + 1),
  localparam int CNT_W = $clog2(TOTAL_PBS_NB + 1),
  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
) (
  input  logic             clk,
  input  logic             s_rst_n,
  input  logic             in_pbs_vld,
  output logic             in_pbs_rdy,
  output logic [PID_W-1:0] in_pid,
  output logic [GID_W-1:0] in_gid,
  input  logic             flush,
  output logic             bcmd_vld,
  input  logic             bcmd_rdy,
  output logic [PID_W-1:0] bcmd_pid_start,
  output logic [NB_W-1:0]  bcmd_pbs_nb,
  input  logic             done_vld,
  input  logic [NB_W-1:0]  done_pbs_nb,
  output logic [CNT_W-1:0] free_cnt,
  output logic             err
);

  // state | meaning
  // IDLE  | no open batch
  // FILL  | open batch collecting requests, idle timer running
  // ISSUE | batch command presented, waiting for bcmd_rdy
  typedef enum logic [1:0] {IDLE, FILL, ISSUE} state_t;

  state_t           state, state_nxt;
  logic [PID_W-1:0] wr_ptr, rd_ptr, rd_ptr_nxt, batch_start;
  logic [PID_W:0]   rd_sum;
  logic [NB_W-1:0]  batch_cnt, batch_cnt_nxt;
  logic [TMR_W-1:0] timer, timer_nxt;
  logic [CNT_W-1:0] occupied, occ_nxt, issued;
  logic             accept, over_release, release_ok;

  assign in_pbs_rdy     = s_rst_n && (state != ISSUE) && (occupied < CNT_W'(TOTAL_PBS_NB));
  assign accept         = in_pbs_vld && in_pbs_rdy;
  assign in_pid         = wr_ptr;
  assign in_gid         = GID_W'(wr_ptr % PID_W'(GRAM_NB));
  assign bcmd_vld       = (state == ISSUE);
  assign bcmd_pid_start = batch_start;
  assign bcmd_pbs_nb    = batch_cnt;

  // Slots of the open or pending batch are not yet issued and cannot be released.
  assign issued       = occupied - CNT_W'(batch_cnt);
  assign over_release = done_vld && (CNT_W'(done_pbs_nb) > issued);
  assign release_ok   = done_vld && !over_release;
  assign occ_nxt      = occupied + CNT_W'(accept) - (release_ok ? CNT_W'(done_pbs_nb) : '0);

  assign rd_sum     = {1'b0, rd_ptr} + (PID_W+1)'(done_pbs_nb);
  assign rd_ptr_nxt = (rd_sum >= (PID_W+1)'(TOTAL_PBS_NB))
                      ? PID_W'(rd_sum - (PID_W+1)'(TOTAL_PBS_NB)) : rd_sum[PID_W-1:0];

  // Timer counts down from TIMEOUT-1 after each accept; zero marks the idle timeout.
  always_comb begin
    state_nxt     = state;
    batch_cnt_nxt = batch_cnt;
    timer_nxt     = timer;
    case (state)
      IDLE: begin
        if (accept) begin
          batch_cnt_nxt = NB_W'(1);
          timer_nxt     = TMR_W'(TIMEOUT - 1);
          state_nxt     = FILL;
        end
      end
      FILL: begin
        if (accept) begin
          batch_cnt_nxt = batch_cnt + NB_W'(1);
          timer_nxt     = TMR_W'(TIMEOUT - 1);
        end else if (timer != '0) begin
          timer_nxt = timer - TMR_W'(1);
        end
        if (flush || (batch_cnt_nxt == NB_W'(BATCH_PBS_NB)) || (timer == '0) ||
            (occ_nxt == CNT_W'(TOTAL_PBS_NB)))
          state_nxt = ISSUE;
      end
      ISSUE: begin
        if (bcmd_rdy) begin
          batch_cnt_nxt = '0;
          state_nxt     = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      batch_start <= '0;
      batch_cnt   <= '0;
      timer       <= '0;
      occupied    <= '0;
      free_cnt    <= CNT_W'(TOTAL_PBS_NB);
      err         <= 1'b0;
    end else begin
      state     <= state_nxt;
      batch_cnt <= batch_cnt_nxt;
      timer     <= timer_nxt;
      occupied  <= occ_nxt;
      free_cnt  <= CNT_W'(TOTAL_PBS_NB) - occ_nxt;
      err       <= err || over_release;
      if (accept) begin
        wr_ptr <= (wr_ptr == PID_W'(TOTAL_PBS_NB - 1)) ? '0 : wr_ptr + PID_W'(1);
        if (state == IDLE)
          batch_start <= wr_ptr;
      end
      if (release_ok)
        rd_ptr <= rd_ptr_nxt;
    end
  end

endmodule

// File: tb/tb_pep_batch_scheduler.sv
// Directed bench for pep_batch_scheduler: cycle vector table plus multi-cycle sequences
// for timeout, wrap/full, stalled issue, coincident accept/release and mid-batch reset.
module tb_pep_batch_scheduler;
  logic       clk = 1'b0;
  logic       s_rst_n;
  logic       in_pbs_vld, flush, bcmd_rdy, done_vld;
  logic [3:0] done_pbs_nb;
  logic       in_pbs_rdy, bcmd_vld, err;
  logic [4:0] in_pid, bcmd_pid_start, free_cnt;
  logic [1:0] in_gid;
  logic [3:0] bcmd_pbs_nb;

  int checks   = 0;
  int failures = 0;

  pep_batch_scheduler dut (
    .clk(clk), .s_rst_n(s_rst_n),
    .in_pbs_vld(in_pbs_vld), .in_pbs_rdy(in_pbs_rdy), .in_pid(in_pid), .in_gid(in_gid),
    .flush(flush),
    .bcmd_vld(bcmd_vld), .bcmd_rdy(bcmd_rdy), .bcmd_pid_start(bcmd_pid_start),
    .bcmd_pbs_nb(bcmd_pbs_nb),
    .done_vld(done_vld), .done_pbs_nb(done_pbs_nb),
    .free_cnt(free_cnt), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int vld, flush, brdy, dvld, dnb;
    int e_rdy, e_pid, e_gid, e_bvld, e_start, e_nb, e_free, e_err;
  } vec_t;

  vec_t tv[23];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    s_rst_n = 1'b0;
    in_pbs_vld = 1'b0; flush = 1'b0; bcmd_rdy = 1'b0; done_vld = 1'b0; done_pbs_nb = '0;
    repeat (3) @(negedge clk);
    s_rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, acc, bh;
    int bstart[$];
    int bnb[$];

    //        vld fl brdy dv dnb | rdy pid gid bvld start nb free err
    tv[0]  = '{0, 0, 0, 0, 0,   1,  0, 0, 0, 0, 0, 18, 0};
    tv[1]  = '{1, 0, 0, 0, 0,   1,  0, 0, 0, 0, 0, 18, 0};
    tv[2]  = '{1, 0, 0, 0, 0,   1,  1, 1, 0, 0, 0, 17, 0};
    tv[3]  = '{1, 0, 0, 0, 0,   1,  2, 2, 0, 0, 0, 16, 0};
    tv[4]  = '{1, 0, 0, 0, 0,   1,  3, 0, 0, 0, 0, 15, 0};
    tv[5]  = '{1, 0, 0, 0, 0,   1,  4, 1, 0, 0, 0, 14, 0};
    tv[6]  = '{1, 0, 0, 0, 0,   1,  5, 2, 0, 0, 0, 13, 0};
    tv[7]  = '{1, 0, 0, 0, 0,   1,  6, 0, 0, 0, 0, 12, 0};
    tv[8]  = '{1, 0, 0, 0, 0,   1,  7, 1, 0, 0, 0, 11, 0};
    tv[9]  = '{1, 0, 0, 0, 0,   1,  8, 2, 0, 0, 0, 10, 0};
    tv[10] = '{1, 0, 0, 0, 0,   0,  9, 0, 1, 0, 9,  9, 0};
    tv[11] = '{0, 0, 1, 0, 0,   0,  9, 0, 1, 0, 9,  9, 0};
    tv[12] = '{1, 0, 0, 0, 0,   1,  9, 0, 0, 0, 0,  9, 0};
    tv[13] = '{1, 1, 0, 0, 0,   1, 10, 1, 0, 0, 0,  8, 0};
    tv[14] = '{0, 0, 1, 0, 0,   0, 11, 2, 1, 9, 2,  7, 0};
    tv[15] = '{0, 0, 0, 1, 9,   1, 11, 2, 0, 0, 0,  7, 0};
    tv[16] = '{0, 0, 0, 0, 0,   1, 11, 2, 0, 0, 0, 16, 0};
    tv[17] = '{0, 0, 0, 1, 3,   1, 11, 2, 0, 0, 0, 16, 0};
    tv[18] = '{0, 0, 0, 0, 0,   1, 11, 2, 0, 0, 0, 16, 1};
    tv[19] = '{0, 1, 0, 0, 0,   1, 11, 2, 0, 0, 0, 16, 1};
    tv[20] = '{0, 0, 0, 0, 0,   1, 11, 2, 0, 0, 0, 16, 1};
    tv[21] = '{0, 0, 0, 1, 2,   1, 11, 2, 0, 0, 0, 16, 1};
    tv[22] = '{0, 0, 0, 0, 0,   1, 11, 2, 0, 0, 0, 18, 1};

    @(negedge clk);
    do_reset();
    #1;
    chk("reset bcmd_vld", 32'(bcmd_vld), 0);
    chk("reset err", 32'(err), 0);
    chk("reset free_cnt", 32'(free_cnt), 18);
    @(negedge clk);

    for (int i = 0; i < 23; i++) begin
      in_pbs_vld  = (tv[i].vld != 0);
      flush       = (tv[i].flush != 0);
      bcmd_rdy    = (tv[i].brdy != 0);
      done_vld    = (tv[i].dvld != 0);
      done_pbs_nb = 4'(tv[i].dnb);
      #1;
      chk($sformatf("v%0d in_pbs_rdy", i), 32'(in_pbs_rdy), tv[i].e_rdy);
      chk($sformatf("v%0d in_pid", i), 32'(in_pid), tv[i].e_pid);
      chk($sformatf("v%0d in_gid", i), 32'(in_gid), tv[i].e_gid);
      chk($sformatf("v%0d bcmd_vld", i), 32'(bcmd_vld), tv[i].e_bvld);
      if (tv[i].e_bvld != 0) begin
        chk($sformatf("v%0d bcmd_pid_start", i), 32'(bcmd_pid_start), tv[i].e_start);
        chk($sformatf("v%0d bcmd_pbs_nb", i), 32'(bcmd_pbs_nb), tv[i].e_nb);
      end
      chk($sformatf("v%0d free_cnt", i), 32'(free_cnt), tv[i].e_free);
      chk($sformatf("v%0d err", i), 32'(err), tv[i].e_err);
      cyc();
    end

    // Idle timeout: three requests, then exactly 64 idle cycles before bcmd_vld
    do_reset();
    in_pbs_vld = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1 chk("timeout req rdy", 32'(in_pbs_rdy), 1);
      cyc();
    end
    in_pbs_vld = 1'b0;
    n = 0;
    #1;
    while (!bcmd_vld && n < 200) begin
      n++;
      cyc();
      #1;
    end
    chk("timeout idle cycles", n, 64);
    chk("timeout pbs_nb", 32'(bcmd_pbs_nb), 3);
    chk("timeout pid_start", 32'(bcmd_pid_start), 0);
    bcmd_rdy = 1'b1;
    cyc();
    bcmd_rdy = 1'b0;
    #1 chk("timeout back to idle", 32'(bcmd_vld), 0);

    // 18 requests with no release: two full batches, full stall, then wrap
    do_reset();
    bcmd_rdy = 1'b1;
    acc = 0;
    for (int c = 0; c < 60 && acc < 18; c++) begin
      in_pbs_vld = 1'b1;
      #1;
      if (bcmd_vld) begin
        bstart.push_back(int'(bcmd_pid_start));
        bnb.push_back(int'(bcmd_pbs_nb));
      end
      if (in_pbs_rdy) begin
        chk("fill18 pid", 32'(in_pid), acc);
        chk("fill18 gid", 32'(in_gid), acc % 3);
        acc++;
      end
      cyc();
    end
    in_pbs_vld = 1'b0;
    chk("fill18 accepted", acc, 18);
    #1;
    chk("fill18 second bcmd_vld", 32'(bcmd_vld), 1);
    if (bcmd_vld) begin
      bstart.push_back(int'(bcmd_pid_start));
      bnb.push_back(int'(bcmd_pbs_nb));
    end
    chk("fill18 free_cnt full", 32'(free_cnt), 0);
    cyc();
    bcmd_rdy = 1'b0;
    #1;
    chk("full in_pbs_rdy", 32'(in_pbs_rdy), 0);
    chk("full free_cnt", 32'(free_cnt), 0);
    chk("batch count", bstart.size(), 2);
    if (bstart.size() == 2) begin
      chk("batch0 start", bstart[0], 0);
      chk("batch0 nb", bnb[0], 9);
      chk("batch1 start", bstart[1], 9);
      chk("batch1 nb", bnb[1], 9);
    end
    done_vld = 1'b1; done_pbs_nb = 4'd9;
    cyc();
    done_vld = 1'b0; done_pbs_nb = '0;
    #1;
    chk("release9 free_cnt", 32'(free_cnt), 9);
    chk("release9 in_pbs_rdy", 32'(in_pbs_rdy), 1);
    chk("wrap pid", 32'(in_pid), 0);
    chk("release9 err", 32'(err), 0);

    // bcmd_rdy held low: fields stable, no requests accepted
    do_reset();
    in_pbs_vld = 1'b1;
    repeat (9) cyc();
    for (int k = 0; k < 10; k++) begin
      #1;
      chk("stall bcmd_vld", 32'(bcmd_vld), 1);
      chk("stall pid_start", 32'(bcmd_pid_start), 0);
      chk("stall pbs_nb", 32'(bcmd_pbs_nb), 9);
      chk("stall in_pbs_rdy", 32'(in_pbs_rdy), 0);
      cyc();
    end
    in_pbs_vld = 1'b0; bcmd_rdy = 1'b1;
    cyc();
    bcmd_rdy = 1'b0;

    // Accept coinciding with a release of 4 at occupancy 10
    in_pbs_vld = 1'b1;
    cyc();
    done_vld = 1'b1; done_pbs_nb = 4'd4;
    #1;
    chk("coinc pid", 32'(in_pid), 10);
    chk("coinc rdy", 32'(in_pbs_rdy), 1);
    chk("coinc free before", 32'(free_cnt), 8);
    cyc();
    in_pbs_vld = 1'b0; done_vld = 1'b0; done_pbs_nb = '0;
    #1;
    chk("coinc free after", 32'(free_cnt), 11);
    chk("coinc err", 32'(err), 0);
    cyc();

    // Over-release with nothing issued, then reset during FILL
    do_reset();
    in_pbs_vld = 1'b1;
    repeat (2) cyc();
    in_pbs_vld = 1'b0;
    done_vld = 1'b1; done_pbs_nb = 4'd5;
    cyc();
    done_vld = 1'b0; done_pbs_nb = '0;
    #1;
    chk("overrel err", 32'(err), 1);
    chk("overrel free_cnt", 32'(free_cnt), 16);
    #2 s_rst_n = 1'b0;
    #1;
    chk("midrst in_pbs_rdy", 32'(in_pbs_rdy), 0);
    chk("midrst bcmd_vld", 32'(bcmd_vld), 0);
    chk("midrst err", 32'(err), 0);
    chk("midrst free_cnt", 32'(free_cnt), 18);
    chk("midrst in_pid", 32'(in_pid), 0);
    repeat (2) @(negedge clk);
    s_rst_n = 1'b1;
    #1 chk("postrst in_pbs_rdy", 32'(in_pbs_rdy), 1);
    bh = 0;
    for (int k = 0; k < 80; k++) begin
      cyc();
      if (bcmd_vld) bh++;
    end
    chk("postrst no bcmd", bh, 0);
    chk("postrst free_cnt", 32'(free_cnt), 18);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
